// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: branch FSM encoding, forwarding selects,
// register-number width and the source/producer match helper.
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    BR_IDLE    = 2'd0,
    BR_WAIT    = 2'd1,
    BR_RESOLVE = 2'd2
  } br_state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // A producer stage matches a source only when it writes a non-zero register.
  function automatic logic src_match(input logic             regwrite,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] src);
    return regwrite && (rd == src) && (rd != '0);
  endfunction

endpackage

// File: rtl/comparator.sv
// Equality comparator used to resolve BEQ/BNE in the ID stage.
module comparator #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             equal
);

  assign equal = (a == b);

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution: hazard stall FSM, operand forwarding into the
// equality comparator, PC-select / IF-ID flush and a taken-branch counter.
module branch_ctrl
  import pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [XLEN-1:0]  id_rs_data,
  input  logic [XLEN-1:0]  id_rt_data,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             kill,
  output logic             stall,
  output logic             pc_src,
  output logic             flush_ifid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] taken_cnt
);

  br_state_t  state_reg, state_next;
  logic [1:0] cnt_reg, cnt_next;
  logic [1:0] need;
  logic       is_branch, resolve, equal, taken;
  logic       a_ex, b_ex, a_mem, b_mem, a_wb, b_wb;
  logic [1:0] sel_a, sel_b;
  logic [XLEN-1:0] op_a, op_b;

  assign is_branch = id_valid && (id_beq || id_bne);

  assign a_ex  = src_match(ex_regwrite,  ex_rd,  id_rs);
  assign b_ex  = src_match(ex_regwrite,  ex_rd,  id_rt);
  assign a_mem = src_match(mem_regwrite, mem_rd, id_rs);
  assign b_mem = src_match(mem_regwrite, mem_rd, id_rt);
  assign a_wb  = src_match(wb_regwrite,  wb_rd,  id_rs);
  assign b_wb  = src_match(wb_regwrite,  wb_rd,  id_rt);

  always_comb begin
    need = 2'd0;
    if ((a_ex || b_ex) && ex_memread)
      need = 2'd2;
    else if (a_ex || b_ex || ((a_mem || b_mem) && mem_memread))
      need = 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= BR_IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // need is sampled only in IDLE; ID is frozen while stalled.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall      = 1'b0;
    resolve    = 1'b0;
    case (state_reg)
      BR_IDLE: begin
        if (is_branch) begin
          if (need == 2'd0) begin
            resolve = 1'b1;
          end else begin
            stall      = 1'b1;
            cnt_next   = need - 2'd1;
            state_next = (need == 2'd1) ? BR_RESOLVE : BR_WAIT;
          end
        end
      end
      BR_WAIT: begin
        stall    = 1'b1;
        cnt_next = (cnt_reg == 2'd0) ? 2'd0 : cnt_reg - 2'd1;
        if (cnt_next == 2'd0)
          state_next = BR_RESOLVE;
      end
      BR_RESOLVE: begin
        resolve    = is_branch;
        state_next = BR_IDLE;
      end
      default: state_next = BR_IDLE;
    endcase
    if (kill) begin
      state_next = BR_IDLE;
      cnt_next   = 2'd0;
      stall      = 1'b0;
      resolve    = 1'b0;
    end
    if (rst) begin
      stall   = 1'b0;
      resolve = 1'b0;
    end
  end

  // MEM beats WB; a load in MEM has no value to forward yet.
  assign sel_a = !resolve                  ? FWD_RF  :
                 (a_mem && !mem_memread)   ? FWD_MEM :
                 a_wb                      ? FWD_WB  : FWD_RF;
  assign sel_b = !resolve                  ? FWD_RF  :
                 (b_mem && !mem_memread)   ? FWD_MEM :
                 b_wb                      ? FWD_WB  : FWD_RF;

  always_comb begin
    case (sel_a)
      FWD_MEM: op_a = mem_alu_result;
      FWD_WB:  op_a = wb_data;
      default: op_a = id_rs_data;
    endcase
    case (sel_b)
      FWD_MEM: op_b = mem_alu_result;
      FWD_WB:  op_b = wb_data;
      default: op_b = id_rt_data;
    endcase
  end

  comparator #(.WIDTH(XLEN)) u_cmp (
    .a     (op_a),
    .b     (op_b),
    .equal (equal)
  );

  assign taken      = resolve && (id_beq ? equal : !equal);
  assign pc_src     = taken;
  assign flush_ifid = taken;
  assign fwd_a      = sel_a;
  assign fwd_b      = sel_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      taken_cnt <= '0;
    else if (taken)
      taken_cnt <= taken_cnt + 1'b1;
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: per-cycle vector table through a
// scoreboard queue, plus counter-wrap and asynchronous-reset sequences.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_beq, id_bne;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_rs_data, id_rt_data;
  logic        ex_regwrite, ex_memread;
  logic [4:0]  ex_rd;
  logic        mem_regwrite, mem_memread;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        kill;
  logic        stall, pc_src, flush_ifid;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] taken_cnt;

  branch_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_beq(id_beq), .id_bne(id_bne),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .kill(kill),
    .stall(stall), .pc_src(pc_src), .flush_ifid(flush_ifid),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid, beq, bne;
    logic [4:0]  rs, rt;
    logic [31:0] rs_data, rt_data;
    logic        ex_rw, ex_mr;
    logic [4:0]  ex_rd;
    logic        mem_rw, mem_mr;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        kill;
    logic        e_stall, e_taken;
    logic [1:0]  e_fa, e_fb;
  } vec_t;

  typedef struct {
    string      name;
    logic       stall, taken;
    logic [1:0] fa, fb;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = 16'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic vec_t idle_v(input string nm);
    vec_t v;
    v.name = nm; v.valid = 0; v.beq = 0; v.bne = 0; v.rs = 0; v.rt = 0;
    v.rs_data = 0; v.rt_data = 0; v.ex_rw = 0; v.ex_mr = 0; v.ex_rd = 0;
    v.mem_rw = 0; v.mem_mr = 0; v.mem_rd = 0; v.mem_alu = 0;
    v.wb_rw = 0; v.wb_rd = 0; v.wb_data = 0; v.kill = 0;
    v.e_stall = 0; v.e_taken = 0; v.e_fa = 0; v.e_fb = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_beq = v.beq; id_bne = v.bne;
    id_rs = v.rs; id_rt = v.rt; id_rs_data = v.rs_data; id_rt_data = v.rt_data;
    ex_regwrite = v.ex_rw; ex_memread = v.ex_mr; ex_rd = v.ex_rd;
    mem_regwrite = v.mem_rw; mem_memread = v.mem_mr; mem_rd = v.mem_rd;
    mem_alu_result = v.mem_alu;
    wb_regwrite = v.wb_rw; wb_rd = v.wb_rd; wb_data = v.wb_data;
    kill = v.kill;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic apply_vec(input vec_t v);
    exp_t e;
    drive(v);
    e.name = v.name; e.stall = v.e_stall; e.taken = v.e_taken; e.fa = v.e_fa; e.fb = v.e_fb;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.name, ".stall"}, 32'(stall), 32'(e.stall));
    check({e.name, ".pc_src"}, 32'(pc_src), 32'(e.taken));
    check({e.name, ".flush_ifid"}, 32'(flush_ifid), 32'(e.taken));
    check({e.name, ".fwd_a"}, 32'(fwd_a), 32'(e.fa));
    check({e.name, ".fwd_b"}, 32'(fwd_b), 32'(e.fb));
    if (e.taken) exp_cnt = exp_cnt + 16'h1;
    @(posedge clk);
    #1;
    check({e.name, ".taken_cnt"}, 32'(taken_cnt), 32'(exp_cnt));
    $display("vec %-16s stall=%0d pc_src=%0d fwd_a=%0d fwd_b=%0d taken_cnt=0x%04h",
             e.name, stall, pc_src, fwd_a, fwd_b, taken_cnt);
  endtask

  task automatic build_table();
    vec_t v;
    tbl.push_back(idle_v("idle"));
    v = idle_v("beq_nohaz_t"); v.valid = 1; v.beq = 1; v.rs = 3; v.rt = 3;
    v.rs_data = 32'h10; v.rt_data = 32'h10; v.e_taken = 1; tbl.push_back(v);
    v = idle_v("beq_nohaz_nt"); v.valid = 1; v.beq = 1; v.rs = 3; v.rt = 4;
    v.rs_data = 32'h10; v.rt_data = 32'h11; tbl.push_back(v);
    v = idle_v("bne_nohaz_t"); v.valid = 1; v.bne = 1; v.rs = 1; v.rt = 2;
    v.rs_data = 32'h1; v.rt_data = 32'h2; v.e_taken = 1; tbl.push_back(v);
    v = idle_v("nonbranch_haz"); v.valid = 1; v.rs = 5; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 5;
    tbl.push_back(v);
    v = idle_v("invalid_beq"); v.beq = 1; v.rs = 5; v.ex_rw = 1; v.ex_rd = 5; tbl.push_back(v);
    // ALU producer in EX, one stall, then forward from MEM
    v = idle_v("alu_ex_stall"); v.valid = 1; v.bne = 1; v.rs = 5; v.rt = 0;
    v.ex_rw = 1; v.ex_rd = 5; v.e_stall = 1; tbl.push_back(v);
    v = idle_v("alu_ex_resolve"); v.valid = 1; v.bne = 1; v.rs = 5; v.rt = 0;
    v.mem_rw = 1; v.mem_rd = 5; v.mem_alu = 32'h7; v.e_taken = 1; v.e_fa = 1; tbl.push_back(v);
    // Load in EX, two stalls, then forward from WB
    v = idle_v("ld_ex_stall1"); v.valid = 1; v.beq = 1; v.rs = 4; v.rt = 6;
    v.rs_data = 32'h99; v.rt_data = 32'h20; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 4;
    v.e_stall = 1; tbl.push_back(v);
    v.name = "ld_ex_stall2"; v.ex_rw = 0; v.ex_mr = 0; v.ex_rd = 0;
    v.mem_rw = 1; v.mem_mr = 1; v.mem_rd = 4; tbl.push_back(v);
    v.name = "ld_ex_resolve"; v.mem_rw = 0; v.mem_mr = 0; v.mem_rd = 0;
    v.wb_rw = 1; v.wb_rd = 4; v.wb_data = 32'h20; v.e_stall = 0; v.e_taken = 1; v.e_fa = 2;
    tbl.push_back(v);
    v = idle_v("ld_ex_r0"); v.valid = 1; v.beq = 1; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 0;
    v.e_taken = 1; tbl.push_back(v);
    // Load in MEM, one stall, then forward rt from WB
    v = idle_v("ld_mem_stall"); v.valid = 1; v.beq = 1; v.rs = 2; v.rt = 7; v.rs_data = 32'h5;
    v.mem_rw = 1; v.mem_mr = 1; v.mem_rd = 7; v.e_stall = 1; tbl.push_back(v);
    v.name = "ld_mem_resolve"; v.mem_rw = 0; v.mem_mr = 0; v.mem_rd = 0;
    v.wb_rw = 1; v.wb_rd = 7; v.wb_data = 32'h5; v.e_stall = 0; v.e_taken = 1; v.e_fb = 2;
    tbl.push_back(v);
    v = idle_v("mem_over_wb"); v.valid = 1; v.bne = 1; v.rs = 8; v.rt = 9; v.rt_data = 32'h1;
    v.mem_rw = 1; v.mem_rd = 8; v.mem_alu = 32'h1; v.wb_rw = 1; v.wb_rd = 8; v.wb_data = 32'h2;
    v.e_fa = 1; tbl.push_back(v);
    v = idle_v("wb_rt_fwd"); v.valid = 1; v.beq = 1; v.rs = 8; v.rt = 9; v.rs_data = 32'h33;
    v.wb_rw = 1; v.wb_rd = 9; v.wb_data = 32'h33; v.e_taken = 1; v.e_fb = 2; tbl.push_back(v);
    v = idle_v("kill_idle"); v.valid = 1; v.beq = 1; v.rs = 3; v.rt = 3; v.kill = 1;
    tbl.push_back(v);
    // Kill on the second stall cycle; the following ALU hazard must stall from IDLE
    v = idle_v("kill_stall1"); v.valid = 1; v.beq = 1; v.rs = 4; v.rt = 6;
    v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 4; v.e_stall = 1; tbl.push_back(v);
    v.name = "kill_stall2"; v.ex_rw = 0; v.ex_mr = 0; v.ex_rd = 0;
    v.mem_rw = 1; v.mem_mr = 1; v.mem_rd = 4; v.kill = 1; v.e_stall = 0; tbl.push_back(v);
    v = idle_v("post_kill_stall"); v.valid = 1; v.beq = 1; v.rs = 1; v.rt = 1;
    v.ex_rw = 1; v.ex_rd = 1; v.e_stall = 1; tbl.push_back(v);
    v = idle_v("post_kill_res"); v.valid = 1; v.beq = 1; v.rs = 1; v.rt = 1;
    v.mem_rw = 1; v.mem_rd = 1; v.mem_alu = 32'hABC; v.e_taken = 1; v.e_fa = 1; v.e_fb = 1;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t v;
    int   n;
    rst = 1'b1;
    drive(idle_v("init"));
    #1;
    check("reset.stall", 32'(stall), 32'h0);
    check("reset.pc_src", 32'(pc_src), 32'h0);
    check("reset.taken_cnt", 32'(taken_cnt), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    build_table();
    foreach (tbl[i]) apply_vec(tbl[i]);

    // Counter wrap: run taken branches until 0xFFFF, then one more
    v = idle_v("wrap_fill"); v.valid = 1; v.beq = 1; v.rs = 3; v.rt = 3;
    v.rs_data = 32'h10; v.rt_data = 32'h10; v.e_taken = 1;
    n = 32'hFFFF - int'(exp_cnt);
    drive(v);
    repeat (n) @(posedge clk);
    #1;
    exp_cnt = 16'hFFFF;
    check("wrap.pre", 32'(taken_cnt), 32'(exp_cnt));
    $display("vec %-16s taken_cnt=0x%04h", "wrap_fill", taken_cnt);
    v.name = "wrap_last";
    apply_vec(v);
    check("wrap.zero", 32'(taken_cnt), 32'h0);

    // Async reset while in WAIT
    v = idle_v("rst_wait"); v.valid = 1; v.beq = 1; v.rs = 4; v.rt = 6;
    v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 4;
    drive(v);
    @(negedge clk);
    check("rst_wait.stall_idle", 32'(stall), 32'h1);
    @(posedge clk);
    #1;
    check("rst_wait.stall_wait", 32'(stall), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_wait.stall", 32'(stall), 32'h0);
    check("rst_wait.pc_src", 32'(pc_src), 32'h0);
    check("rst_wait.flush", 32'(flush_ifid), 32'h0);
    check("rst_wait.fwd", 32'({fwd_a, fwd_b}), 32'h0);
    check("rst_wait.taken_cnt", 32'(taken_cnt), 32'h0);
    $display("vec %-16s stall=%0d pc_src=%0d taken_cnt=0x%04h", "rst_wait", stall, pc_src, taken_cnt);
    exp_cnt = 16'h0;
    @(negedge clk);
    drive(idle_v("rst_idle"));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    v = idle_v("after_rst"); v.valid = 1; v.bne = 1; v.rs = 2; v.rt = 3;
    v.rs_data = 32'h1; v.rt_data = 32'h0; v.e_taken = 1;
    apply_vec(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch-resolution controller for the ID stage of the 5-stage pipeline. It instantiates the 32-bit equality comparator and selects forwarded operands for it. It stalls the front end until both branch sources are available, then resolves BEQ/BNE in ID, driving the PC-select and IF/ID flush. A wrapping counter of taken branches is kept for performance debug.

## Interface
- `XLEN`, 32, datapath width of compared operands
- `CNT_W`, 16, width of the taken-branch counter
- `clk`  in  1  pipeline clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `id_valid`  in  1  ID stage holds a valid instruction
- `id_beq`, `id_bne`  in  1 each  decoded branch type (mutually exclusive)
- `id_rs`, `id_rt`  in  5 each  branch source register numbers
- `id_rs_data`, `id_rt_data`  in  XLEN each  register-file read data
- `ex_regwrite`, `ex_memread`  in  1 each  EX-stage instruction writes a register / is a load
- `ex_rd`  in  5  EX-stage destination
- `mem_regwrite`, `mem_memread`  in  1 each  MEM-stage equivalents
- `mem_rd`  in  5  MEM-stage destination
- `mem_alu_result`  in  XLEN  MEM-stage ALU result
- `wb_regwrite`  in  1  WB-stage write enable
- `wb_rd`  in  5  WB-stage destination
- `wb_data`  in  XLEN  WB write-back value
- `kill`  in  1  flush from a later stage; aborts any pending branch
- `stall`  out  1  freeze PC and IF/ID, insert bubble into ID/EX
- `pc_src`  out  1  select branch target for next PC
- `flush_ifid`  out  1  zero IF/ID
- `fwd_a`, `fwd_b`  out  2 each  operand source: 0 regfile, 1 MEM ALU, 2 WB
- `taken_cnt`  out  CNT_W  count of taken branches, wraps

## Operation
- Branch = `id_valid & (id_beq | id_bne)`. A source "matches" a stage when that stage's regwrite is set, its rd equals the source, and rd ≠ 0. Register 0 never hazards or forwards.
- Required stall count `need`:
  - 2 if either source matches EX with `ex_memread`.
  - else 1 if either source matches EX (ALU), or matches MEM with `mem_memread`.
  - else 0.
- FSM states: IDLE, WAIT, RESOLVE.
  - IDLE, branch, need = 0: resolve this cycle, stay in IDLE.
  - IDLE, branch, need > 0: `stall` = 1, load `cnt` ← need−1, go to WAIT if cnt > 0, else RESOLVE.
  - WAIT: `stall` = 1, decrement `cnt`; go to RESOLVE when `cnt` = 0.
  - RESOLVE: `stall` = 0, resolve, go to IDLE.
- Resolve:
  - Each operand is forwarded from MEM if it matches MEM and `!mem_memread`; else from WB if it matches WB; else from the regfile. MEM has priority over WB.
  - The comparator's `equal` drives taken = beq ? equal : !equal.
  - `pc_src` = `flush_ifid` = taken, and `taken_cnt` increments on the next edge.
- `fwd_a`/`fwd_b` are 0 outside resolve cycles.
- `kill` has priority over everything:
  - next state is IDLE and `cnt` is cleared;
  - `stall`, `pc_src`, `flush_ifid` are forced to 0 that cycle;
  - `taken_cnt` does not increment.
- A non-branch in ID never asserts any output.

## Timing
- Reset (async): state IDLE, `cnt` 0, `taken_cnt` 0. All combinational outputs are 0 while `rst` is high.
- Latency from the branch first appearing in ID to resolve:
  - 0 cycles when no hazard;
  - 1 stall cycle for an ALU producer in EX or a load in MEM;
  - 2 stall cycles for a load in EX.
- `stall`, `pc_src`, `flush_ifid`, `fwd_*` are combinational from state and inputs within the cycle. `taken_cnt` is registered.
- `taken_cnt` wraps from 2^CNT_W−1 to 0 with no flag.
- Reset asserted mid-WAIT returns to IDLE immediately. The branch is not resolved.
- In WAIT the pipeline holds ID, so ID inputs stay stable. The FSM must not re-evaluate `need` in WAIT or RESOLVE.

## Structure
- A shared package `pipe_pkg` holds:
  - the FSM state encoding (`BR_IDLE`, `BR_WAIT`, `BR_RESOLVE`);
  - forwarding-select constants (`FWD_RF` = 0, `FWD_MEM` = 1, `FWD_WB` = 2);
  - the register-number width of 5.
- One sub-module: the existing `comparator` (32-bit equality), instantiated once and fed by the two forwarding muxes.

## Test plan
- No hazard: BEQ, rs = rt = 3, regfile data 0x10 / 0x10 → same cycle `pc_src` = `flush_ifid` = 1, `stall` = 0, `taken_cnt` 0→1.
- ALU producer in EX writes r5 (result 0x7), then BNE r5, r0 → 1 cycle `stall`. Resolve cycle has `fwd_a` = 1 and `mem_alu_result` = 0x7, giving taken.
- Load in EX writes r4, then BEQ r4, r6 → 2 stall cycles. Resolve has `fwd_a` = 2, `wb_data` = 0x20 vs rt 0x20, giving taken.
- Load in EX targeting r0 with BEQ r0, r0 → no stall, taken.
- `kill` asserted during the second stall cycle → `stall` drops that cycle, state IDLE next edge, `pc_src` never asserted, `taken_cnt` unchanged.
- Preload 0xFFFF taken branches (or force the counter), then one taken branch → `taken_cnt` = 0x0000. Async `rst` mid-WAIT → all outputs 0 immediately.
